sqrt_arbiter: RTL

- Shares one fixed-latency SquareRoot core between NUM_REQ requesters, such as per-pixel shading/normalisation units.
- Accepts 12-bit operands through a valid/ready handshake and arbitrates round-robin.
- Sequences the core's start pulse, waits a fixed SQRT_LATENCY cycles, captures Q and returns it to the winning requester through a per-requester valid/ready response.
- Exactly one operation is in flight at a time.

---
 rtl/sqrt_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter sharing one fixed-latency square-root core between
// NUM_REQ requesters; one operation in flight, per-requester response handshake.
module sqrt_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned W            = 12,
    parameter int unsigned SQRT_LATENCY = 18
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_operand,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_data,
    output logic                 sqrt_start,
    output logic [W-1:0]         sqrt_a,
    input  logic [W-1:0]         sqrt_q,
    output logic                 busy
);

    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW  = $clog2(SQRT_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  last_grant;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [W-1:0]    win_op;
    int              j;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        win_op    = '0;
        j         = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            j = int'(last_grant) + 1 + k;
            if (j >= int'(NUM_REQ)) begin
                j = j - int'(NUM_REQ);
            end
            if (!win_found && req_valid[j]) begin
                win_found = 1'b1;
                win_id    = IDW'(j);
                win_op    = req_operand[j*W +: W];
            end
        end
    end

    // Accept is offered only to the current winner while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (rst_ && (state == IDLE) && win_found) begin
            req_ready[win_id] = 1'b1;
        end
    end

    // Operation sequencer: accept, start pulse, latency wait, response hold
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state      <= IDLE;
            cnt        <= '0;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
            rsp_data   <= '0;
            sqrt_a     <= '0;
            rsp_valid  <= '0;
            sqrt_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        sqrt_a     <= win_op;
                        grant_id   <= win_id;
                        last_grant <= win_id;
                        busy       <= 1'b1;
                        if (win_op != '0) begin
                            sqrt_start <= 1'b1;
                            state      <= ISSUE;
                        end else begin
                            // sqrt(0) is 0: skip the core entirely
                            rsp_data  <= '0;
                            rsp_valid <= NUM_REQ'(1) << win_id;
                            state     <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    sqrt_start <= 1'b0;
                    cnt        <= CW'(SQRT_LATENCY);
                    state      <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        rsp_data  <= sqrt_q;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_id]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
